debug_reg_dump: RTL and testbench

DEBUG_REG_DUMP -- requirements
Module: debug_reg_dump

---
 rtl/debug_reg_dump_pkg.sv | 25 ++
 rtl/debug_reg_dump.sv | 132 +++++++++++++
 tb/tb_debug_reg_dump.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_reg_dump_pkg.sv
// Shared debug package: dump FSM state encoding and register/byte geometry.
package debug_reg_dump_pkg;

  localparam int unsigned DEFAULT_NB = 32;

  // Bytes needed to serialise one register of width nb (nb is a multiple of 8).
  function automatic int unsigned bytes_per_reg(input int unsigned nb);
    return nb / 8;
  endfunction

  localparam int unsigned BYTES_PER_REG = bytes_per_reg(DEFAULT_NB);

  // Byte counter width; kept at least one bit so an 8-bit register file still elaborates.
  function automatic int unsigned byte_cnt_w(input int unsigned nb);
    return (nb / 8 > 1) ? $clog2(nb / 8) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

endpackage : debug_reg_dump_pkg

// File: rtl/debug_reg_dump.sv
// Streams the whole register file out over a byte-wide valid/ready link,
// one register at a time, most significant byte first.
//
// Ports:
//   i_clk       clock, all state changes on its rising edge
//   i_reset     asynchronous active-low reset
//   i_start     request a full dump (sampled only while idle)
//   i_abort     drop any dump in progress, back to idle with no done pulse
//   o_reg_dir   register index presented to the register-file debug read port
//   i_reg_data  combinational read data for o_reg_dir
//   o_tx_data   byte to the UART transmitter
//   o_tx_valid  o_tx_data is valid
//   i_tx_ready  transmitter accepts the byte this cycle
//   o_busy      high whenever not idle
//   o_done      one-cycle pulse after the final byte of the final register
module debug_reg_dump
  import debug_reg_dump_pkg::*;
#(
  parameter int unsigned NB   = DEFAULT_NB,
  parameter int unsigned REGS = 5,
  parameter int unsigned TAM  = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_abort,
  output logic [REGS-1:0] o_reg_dir,
  input  logic [NB-1:0]   i_reg_data,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_valid,
  input  logic            i_tx_ready,
  output logic            o_busy,
  output logic            o_done
);

  localparam int unsigned BPR = bytes_per_reg(NB);
  localparam int unsigned BCW = byte_cnt_w(NB);
  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BPR - 1);
  localparam logic [REGS-1:0] LAST_IDX  = REGS'(TAM - 1);

  dump_state_e     state_q, state_d;
  logic [REGS-1:0] idx_q;
  logic [BCW-1:0]  byte_q;
  logic [NB-1:0]   shift_q;

  logic xfer_c;
  logic last_byte_c;
  logic last_reg_c;

  // A transfer only exists while a byte is actually offered.
  assign xfer_c      = (state_q == ST_SEND) && i_tx_ready;
  assign last_byte_c = (byte_q == LAST_BYTE);
  assign last_reg_c  = (idx_q == LAST_IDX);

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other condition.
  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (i_start) state_d = ST_ADDR;
        ST_ADDR: state_d = ST_SEND;
        ST_SEND: begin
          if (xfer_c && last_byte_c) begin
            state_d = last_reg_c ? ST_DONE : ST_ADDR;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Index / byte counter / shift register datapath.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      idx_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
    end else if (!i_abort) begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            idx_q  <= '0;
            byte_q <= '0;
          end
        end
        // Read data is only trusted here; later changes cannot disturb the bytes in flight.
        ST_ADDR: shift_q <= i_reg_data;
        ST_SEND: begin
          if (xfer_c) begin
            if (!last_byte_c) begin
              shift_q <= shift_q << 8;
              byte_q  <= byte_q + BCW'(1);
            end else if (!last_reg_c) begin
              idx_q  <= idx_q + REGS'(1);
              byte_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state, so reset clears them immediately.
  always_comb begin
    o_tx_valid = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    o_reg_dir  = idx_q;
    o_tx_data  = shift_q[NB-1 -: 8];
    unique case (state_q)
      ST_IDLE: o_busy     = 1'b0;
      ST_ADDR: ;
      ST_SEND: o_tx_valid = 1'b1;
      ST_DONE: o_done     = 1'b1;
      default: o_busy     = 1'b0;
    endcase
  end

endmodule : debug_reg_dump

// File: tb/tb_debug_reg_dump.sv
// Scoreboard bench for debug_reg_dump: stimulus pushes expected bytes, a
// negedge monitor pops and compares each accepted byte.
module tb_debug_reg_dump;
  import debug_reg_dump_pkg::*;

  localparam int unsigned NB   = 32;
  localparam int unsigned REGS = 5;
  localparam int unsigned TAM  = 32;
  // Per register: one ADDR cycle + four SEND cycles; DONE is entered at edge 5*TAM.
  localparam int DONE_CYC = 5 * TAM;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_start;
  logic            i_abort;
  logic [REGS-1:0] o_reg_dir;
  logic [NB-1:0]   i_reg_data;
  logic [7:0]      o_tx_data;
  logic            o_tx_valid;
  logic            i_tx_ready;
  logic            o_busy;
  logic            o_done;

  logic [NB-1:0] regs [TAM];
  logic [7:0]    exp_q [$];
  int checks = 0;
  int failures = 0;
  int done_pulses = 0;
  int xfer_cnt = 0;
  int ready_mode = 0;  // 0: always ready, 1: ready one cycle in three, 2: never ready
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  debug_reg_dump #(.NB(NB), .REGS(REGS), .TAM(TAM)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .o_reg_dir  (o_reg_dir),
    .i_reg_data (i_reg_data),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  // Register file; read data is garbage whenever a byte is on offer, so only ADDR captures count.
  assign i_reg_data = o_tx_valid ? 32'hDEAD_BEEF : regs[o_reg_dir];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready driver.
  initial begin
    int ph = 0;
    i_tx_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      case (ready_mode)
        0: i_tx_ready = 1'b1;
        1: i_tx_ready = (ph == 0);
        default: i_tx_ready = 1'b0;
      endcase
      ph = (ph == 2) ? 0 : ph + 1;
    end
  end

  // Monitor / scoreboard.
  always @(negedge i_clk) begin
    if (i_reset) begin
      if (o_done) done_pulses++;
      if (o_tx_valid && prev_stall) chk("hold_stable", 32'(o_tx_data), 32'(prev_data));
      if (o_tx_valid && i_tx_ready && !i_abort) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", o_tx_data, $time);
        end else begin
          chk("byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = o_tx_valid && !i_tx_ready && !i_abort;
      prev_data  = o_tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_dump();
    for (int k = 0; k < int'(TAM); k++) begin
      logic [31:0] w;
      w = 32'hA0B0_C000 + 32'(k);
      for (int b = 0; b < int'(BYTES_PER_REG); b++) exp_q.push_back(w[31 - 8*b -: 8]);
    end
  endtask

  task automatic pulse_start();
    @(posedge i_clk);
    #1 i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  // Full dump; optionally pulses i_start while register 3 is being sent.
  task automatic run_dump(input bit mid_start, input bit check_timing);
    int cyc;
    int first_valid;
    int base_done;
    bit seen;
    base_done = done_pulses;
    push_dump();
    pulse_start();
    chk("busy_after_start", 32'(o_busy), 32'd1);
    cyc = 0;
    first_valid = -1;
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(posedge i_clk);
      #1;
      cyc++;
      if (first_valid < 0 && o_tx_valid) first_valid = cyc;
      if (mid_start && cyc == 17) begin
        chk("mid_start_reg", 32'(o_reg_dir), 32'd3);
        i_start = 1'b1;
      end
      if (mid_start && cyc == 18) i_start = 1'b0;
      if (o_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done within 2000 cycles");
    end
    if (check_timing) begin
      chk("first_valid_cyc", 32'(first_valid), 32'd1);
      chk("done_cyc", 32'(cyc), 32'(DONE_CYC));
    end
    @(posedge i_clk);
    #1;
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("idle_after_done", 32'(o_busy), 32'd0);
    chk("reg_dir_holds_last", 32'(o_reg_dir), 32'(TAM - 1));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("done_pulse_count", 32'(done_pulses - base_done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int base_done;
    for (int k = 0; k < int'(TAM); k++) regs[k] = 32'hA0B0_C000 + 32'(k);
    i_reset = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    #23;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_valid", 32'(o_tx_valid), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_reg_dir", 32'(o_reg_dir), 32'd0);
    chk("rst_tx_data", 32'(o_tx_data), 32'd0);
    @(posedge i_clk);
    #1 i_reset = 1'b1;
    repeat (2) @(posedge i_clk);

    // Start together with abort stays idle.
    #1 begin i_start = 1'b1; i_abort = 1'b1; end
    @(posedge i_clk);
    #1 begin i_start = 1'b0; i_abort = 1'b0; end
    chk("start_abort_busy", 32'(o_busy), 32'd0);
    chk("start_abort_valid", 32'(o_tx_valid), 32'd0);
    @(posedge i_clk);
    #1 chk("start_abort_busy_later", 32'(o_busy), 32'd0);

    // Full dump at full rate, then again with a start pulse while busy.
    ready_mode = 0;
    run_dump(1'b0, 1'b1);
    run_dump(1'b1, 1'b1);

    // Backpressure: same stream, held data checked by the monitor.
    ready_mode = 1;
    run_dump(1'b0, 1'b0);

    // Abort after the fifth transfer, then restart from register 0.
    ready_mode = 0;
    repeat (3) @(posedge i_clk);
    base = xfer_cnt;
    base_done = done_pulses;
    for (int b = 0; b < 5; b++) begin
      logic [31:0] w;
      w = regs[b / 4];
      exp_q.push_back(w[31 - 8*(b % 4) -: 8]);
    end
    pulse_start();
    for (int n = 0; n < 100 && (xfer_cnt - base) < 5; n++) begin
      @(posedge i_clk);
      #1;
    end
    chk("abort_xfers_seen", 32'(xfer_cnt - base), 32'd5);
    i_abort = 1'b1;
    @(posedge i_clk);
    #1 i_abort = 1'b0;
    chk("abort_valid", 32'(o_tx_valid), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    repeat (5) @(posedge i_clk);
    #1;
    chk("abort_no_done", 32'(done_pulses - base_done), 32'd0);
    chk("abort_queue", 32'(exp_q.size()), 32'd0);
    run_dump(1'b0, 1'b1);

    // Asynchronous reset in the middle of a stalled SEND.
    ready_mode = 2;
    base_done = done_pulses;
    pulse_start();
    repeat (3) @(posedge i_clk);
    #1;
    chk("pre_reset_valid", 32'(o_tx_valid), 32'd1);
    chk("pre_reset_data", 32'(o_tx_data), 32'hA0);
    @(negedge i_clk);
    #2 i_reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(o_tx_valid), 32'd0);
    chk("async_rst_busy", 32'(o_busy), 32'd0);
    chk("async_rst_data", 32'(o_tx_data), 32'd0);
    chk("async_rst_reg_dir", 32'(o_reg_dir), 32'd0);
    chk("async_rst_done", 32'(o_done), 32'd0);
    @(posedge i_clk);
    #1 i_reset = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    chk("post_reset_idle", 32'(o_busy), 32'd0);
    chk("post_reset_no_done", 32'(done_pulses - base_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_debug_reg_dump
